// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit: load-use stall and branch/jump flush control for the ID stage.
// Optional HAZARD_STATS_EN adds a saturating stall-cycle counter on stall_count_o.
module hazard_detect_unit #(
  parameter int STALL_CYCLES = 1,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic              uses_rt_i,
  input  logic              id_memread_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              branch_taken_i,
  input  logic              jump_i,
  output logic              stall_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              flush_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_count_o
`endif
);
  typedef enum logic {IDLE, HOLD} state_e;
  state_e            fsm_q, fsm_d;
  logic              ex_memread_q, ex_memread_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              hazard;
  if (STALL_CYCLES < 1 || STALL_CYCLES > 7) begin : g_bad_stall
    $error("STALL_CYCLES must be within 1..7");
  end
  always_comb begin
    hazard = ex_memread_q && ex_rd_q != '0 &&
             (ex_rd_q == rs_i || (uses_rt_i && ex_rd_q == rt_i));
    stall_o = (fsm_q == IDLE && hazard) || fsm_q == HOLD;
    pc_write_o = ~stall_o;
    ifid_write_o = ~stall_o;
    // reset gating keeps IF/ID quiet while the pipeline is being cleared
    flush_o = (branch_taken_i | jump_i) & ~stall_o & rst_i;
    ex_memread_d = stall_o ? 1'b0 : id_memread_i;
    ex_rd_d = stall_o ? ex_rd_q : id_rd_i;
    fsm_d = fsm_q == HOLD ? (cnt_q == 3'd1 ? IDLE : HOLD)
                          : ((hazard && STALL_CYCLES > 1) ? HOLD : IDLE);
    cnt_d = fsm_q == HOLD ? cnt_q - 3'd1
                          : ((hazard && STALL_CYCLES > 1) ? 3'(STALL_CYCLES - 1) : cnt_q);
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fsm_q <= IDLE;
      cnt_q <= '0;
      ex_memread_q <= 1'b0;
      ex_rd_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      ex_memread_q <= ex_memread_d;
      ex_rd_q <= ex_rd_d;
    end
  end
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count_q, stall_count_d;
  always_comb stall_count_d = (stall_o && stall_count_q != '1) ? stall_count_q + 32'd1 : stall_count_q;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) stall_count_q <= '0;
    else stall_count_q <= stall_count_d;
  end
  assign stall_count_o = stall_count_q;
`endif
endmodule

// File: tb/tb_hazard_detect_unit.sv
// tb_hazard_detect_unit: directed checks of hazard_detect_unit with 1- and 3-cycle load-use penalties.
module tb_hazard_detect_unit;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic [4:0] rs_i = '0, rt_i = '0, id_rd_i = '0;
  logic uses_rt_i = 1'b0, id_memread_i = 1'b0, branch_taken_i = 1'b0, jump_i = 1'b0;
  logic s1, pw1, iw1, f1, s3, pw3, iw3, f3;
`ifdef HAZARD_STATS_EN
  logic [31:0] sc1, sc3;
`endif
  int total = 0, bad = 0;
  always #5 clk_i = ~clk_i;
  hazard_detect_unit #(.STALL_CYCLES(1), .REG_AW(5)) u1 (
    .clk_i(clk_i), .rst_i(rst_i), .rs_i(rs_i), .rt_i(rt_i), .uses_rt_i(uses_rt_i),
    .id_memread_i(id_memread_i), .id_rd_i(id_rd_i), .branch_taken_i(branch_taken_i),
    .jump_i(jump_i), .stall_o(s1), .pc_write_o(pw1), .ifid_write_o(iw1), .flush_o(f1)
`ifdef HAZARD_STATS_EN
    , .stall_count_o(sc1)
`endif
  );
  hazard_detect_unit #(.STALL_CYCLES(3), .REG_AW(5)) u3 (
    .clk_i(clk_i), .rst_i(rst_i), .rs_i(rs_i), .rt_i(rt_i), .uses_rt_i(uses_rt_i),
    .id_memread_i(id_memread_i), .id_rd_i(id_rd_i), .branch_taken_i(branch_taken_i),
    .jump_i(jump_i), .stall_o(s3), .pc_write_o(pw3), .ifid_write_o(iw3), .flush_o(f3)
`ifdef HAZARD_STATS_EN
    , .stall_count_o(sc3)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic mr, input logic [4:0] rd, input logic br, input logic jp);
    rs_i = rs; rt_i = rt; uses_rt_i = urt; id_memread_i = mr; id_rd_i = rd;
    branch_taken_i = br; jump_i = jp;
    #1;
  endtask
  task automatic do_reset(input string tag);
    rst_i = 1'b0;
    drive(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
          1'($urandom), 1'($urandom));
    chk({tag, "_rst_stall1"}, 32'(s1), 32'd0);
    chk({tag, "_rst_pcw1"}, 32'(pw1), 32'd1);
    chk({tag, "_rst_flush1"}, 32'(f1), 32'd0);
    chk({tag, "_rst_stall3"}, 32'(s3), 32'd0);
    chk({tag, "_rst_ifidw3"}, 32'(iw3), 32'd1);
    chk({tag, "_rst_flush3"}, 32'(f3), 32'd0);
`ifdef HAZARD_STATS_EN
    chk({tag, "_rst_count3"}, sc3, 32'd0);
`endif
    tick;
    rst_i = 1'b1;
  endtask
  initial begin
    #1;
    do_reset("t1");
    // t2: lw $2 ; add $3,$2,$4 with one-cycle penalty
    drive(5'd1, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0);
    chk("t2_lw_stall", 32'(s1), 32'd0);
    tick;
    drive(5'd2, 5'd4, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0);
    chk("t2_use_stall", 32'(s1), 32'd1);
    chk("t2_use_pcw", 32'(pw1), 32'd0);
    chk("t2_use_ifidw", 32'(iw1), 32'd0);
    tick;
    chk("t2_after_stall", 32'(s1), 32'd0);
    chk("t2_after_pcw", 32'(pw1), 32'd1);
    tick;
    chk("t2_after2_stall", 32'(s1), 32'd0);
    // t3: lw $2 ; sw $2 with three-cycle penalty
    do_reset("t3");
    drive(5'd1, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0);
    chk("t3_lw_stall", 32'(s3), 32'd0);
    tick;
    drive(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t3_stall_c%0d", i), 32'(s3), 32'd1);
      chk($sformatf("t3_pcw_c%0d", i), 32'(pw3), 32'd0);
      tick;
    end
    chk("t3_release", 32'(s3), 32'd0);
    chk("t3_release_pcw", 32'(pw3), 32'd1);
`ifdef HAZARD_STATS_EN
    chk("t3_count", sc3, 32'd3);
`endif
    // t4: $zero destination and non-matching registers never stall
    do_reset("t4");
    drive(5'd1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    tick;
    drive(5'd0, 5'd0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0);
    chk("t4_zero_stall", 32'(s1), 32'd0);
    tick;
    drive(5'd1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    tick;
    drive(5'd2, 5'd4, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0);
    chk("t4_nomatch_stall", 32'(s1), 32'd0);
    drive(5'd2, 5'd5, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0);
    chk("t4_rt_unused_stall", 32'(s1), 32'd0);
    // t5: stall beats branch flush; branch flushes once resolved
    do_reset("t5");
    drive(5'd1, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0);
    tick;
    drive(5'd2, 5'd7, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("t5_br_stall", 32'(s1), 32'd1);
    chk("t5_br_flush", 32'(f1), 32'd0);
    tick;
    chk("t5_br2_stall", 32'(s1), 32'd0);
    chk("t5_br2_flush", 32'(f1), 32'd1);
    drive(5'd2, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    chk("t5_jump_flush", 32'(f1), 32'd1);
    drive(5'd2, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("t5_idle_flush", 32'(f1), 32'd0);
    // t6: asynchronous reset in the middle of a hold
    do_reset("t6");
    drive(5'd1, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0);
    tick;
    drive(5'd2, 5'd4, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0);
    chk("t6_first_stall", 32'(s3), 32'd1);
    tick;
    chk("t6_hold_stall", 32'(s3), 32'd1);
    #2 rst_i = 1'b0;
    #1;
    chk("t6_async_stall", 32'(s3), 32'd0);
    chk("t6_async_pcw", 32'(pw3), 32'd1);
`ifdef HAZARD_STATS_EN
    chk("t6_async_count", sc3, 32'd0);
`endif
    tick;
    rst_i = 1'b1;
    tick;
    chk("t6_after_stall", 32'(s3), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
